// File: rtl/i2s_apb_master.sv
// Bus initiator for the APB-style register port of I2S transceivers: issues control
// and TxFIFO writes, and polls the RxFIFO into a single-entry receive buffer.
module i2s_apb_master #(
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cfg_valid,
  input  logic              cfg_sel,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              tx_full,
  input  logic              rx_empty,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count
);

  localparam logic [31:0] TX_BASE  = 32'h00;
  localparam logic [31:0] RX_BASE  = 32'h20;
  localparam logic [31:0] CTRL_OFS = 32'h0;
  localparam logic [31:0] TXD_OFS  = 32'h4;
  localparam logic [31:0] RXD_OFS  = 32'h8;

  typedef enum logic [2:0] {IDLE, CFG, WR, RD, CAP} state_t;

  state_t state;
  logic   last;
  logic   tx_elig;
  logic   rx_elig;

  // A read is only worth issuing when the output buffer has room for its result.
  assign tx_elig = s_valid & ~tx_full;
  assign rx_elig = ~rx_empty & ~m_valid;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      last      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      cfg_ready <= 1'b0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
    end else begin
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      cfg_ready <= 1'b0;
      s_ready   <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid  <= 1'b0;
        rx_count <= rx_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            state     <= CFG;
            penable   <= 1'b1;
            pwrite    <= 1'b1;
            paddr     <= (cfg_sel ? RX_BASE : TX_BASE) + CTRL_OFS;
            pwdata    <= cfg_data;
            cfg_ready <= 1'b1;
          end else if (tx_elig && (!rx_elig || !last)) begin
            // last=1 hands the next tie to the receive side
            state   <= WR;
            penable <= 1'b1;
            pwrite  <= 1'b1;
            paddr   <= TX_BASE + TXD_OFS;
            pwdata  <= s_data;
            s_ready <= 1'b1;
            last    <= 1'b1;
          end else if (rx_elig) begin
            state   <= RD;
            penable <= 1'b1;
            pwrite  <= 1'b0;
            paddr   <= RX_BASE + RXD_OFS;
            last    <= 1'b0;
          end
        end
        CFG: state <= IDLE;
        WR: begin
          tx_count <= tx_count + 16'd1;
          state    <= IDLE;
        end
        RD: state <= CAP;
        CAP: begin
          m_data  <= prdata;
          m_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_apb_master.sv
// Directed bench for i2s_apb_master: reset, config, tx flow control, rx buffering,
// arbitration, reset during a transfer and counter wrap.
module tb_i2s_apb_master;
  logic        pclk = 1'b0;
  logic        preset;
  logic        cfg_valid, cfg_sel, cfg_ready;
  logic [31:0] cfg_data;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        tx_full, rx_empty, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [15:0] tx_count, rx_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  logic        mon_wr[$];

  always #5 pclk = ~pclk;

  i2s_apb_master dut (
    .pclk(pclk), .preset(preset),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .tx_full(tx_full), .rx_empty(rx_empty),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  // Record every bus strobe at the edge that ends it.
  always @(posedge pclk) begin
    if (penable) begin
      mon_addr.push_back(paddr);
      mon_data.push_back(pwdata);
      mon_wr.push_back(pwrite);
    end
  end

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_wr.delete();
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cfg_sel = 0; cfg_data = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    tx_full = 0; rx_empty = 1; prdata = 0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1;
    idle_inputs();
    repeat (2) @(negedge pclk);
    preset = 0;
    clear_mon();
  endtask

  // Offers one word; returns at the negedge after the ready cycle with s_valid low.
  task automatic push_word(input logic [31:0] d, input bit full_after, output bit ok);
    ok = 0;
    s_valid = 1;
    s_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge pclk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (full_after) tx_full = 1;
    @(negedge pclk);
    s_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    preset = 1;
    idle_inputs();
    s_valid = 1; s_data = 32'h77; rx_empty = 0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({penable, pwrite, cfg_ready, s_ready, m_valid} !== 5'b0 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: pen=%b pwr=%b addr=%h wdata=%h crdy=%b srdy=%b mv=%b, expected all zero",
               penable, pwrite, paddr, pwdata, cfg_ready, s_ready, m_valid);
    end
    checks++;
    if (m_data !== 32'h0 || tx_count !== 16'h0 || rx_count !== 16'h0 || mon_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h tx=%h rx=%h strobes=%0d, expected 0 0 0 0",
               m_data, tx_count, rx_count, mon_addr.size());
    end
    preset = 0;
    @(negedge pclk);
    checks++;
    if (penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'h04 || pwdata !== 32'h77 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_strobe: pen=%b pwr=%b addr=%h wdata=%h srdy=%b, expected 1 1 00000004 00000077 1",
               penable, pwrite, paddr, pwdata, s_ready);
    end
    rx_empty = 1;
    @(negedge pclk);
    s_valid = 0;
    repeat (3) @(negedge pclk);
    checks++;
    if (tx_count !== 16'd1 || mon_addr.size() != 1) begin
      errors++;
      $display("FAIL reset_after: tx_count=%0d strobes=%0d, expected 1 1", tx_count, mon_addr.size());
    end
  endtask

  task automatic test_config();
    do_reset();
    cfg_valid = 1; cfg_sel = 1; cfg_data = 32'hA5A5_0001;
    @(negedge pclk);
    checks++;
    if (penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'h20 || pwdata !== 32'hA5A5_0001 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_strobe: pen=%b pwr=%b addr=%h wdata=%h crdy=%b, expected 1 1 00000020 a5a50001 1",
               penable, pwrite, paddr, pwdata, cfg_ready);
    end
    @(negedge pclk);
    cfg_valid = 0;
    checks++;
    if (penable !== 1'b0 || cfg_ready !== 1'b0 || pwrite !== 1'b0) begin
      errors++;
      $display("FAIL cfg_one_cycle: pen=%b crdy=%b pwr=%b, expected 0 0 0", penable, cfg_ready, pwrite);
    end
    @(negedge pclk);
    cfg_valid = 1; cfg_sel = 0; cfg_data = 32'h0000_1234;
    @(negedge pclk);
    @(negedge pclk);
    cfg_valid = 0;
    repeat (3) @(negedge pclk);
    checks++;
    if (mon_addr.size() != 2 || mon_addr[1] !== 32'h00 || mon_data[1] !== 32'h1234 || mon_wr[1] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_tx_base: strobes=%0d, expected 2 strobes with second at 00000000 data 00001234", mon_addr.size());
    end
  endtask

  task automatic test_tx_flow();
    bit ok;
    bit saw_ready;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      push_word(i, i == 4, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tx_push_timeout: word %0d got no s_ready, expected a handshake", i);
      end
    end
    s_valid = 1; s_data = 32'd5;
    saw_ready = 0;
    repeat (10) begin
      @(negedge pclk);
      if (s_ready) saw_ready = 1;
    end
    checks++;
    if (saw_ready || mon_addr.size() != 4) begin
      errors++;
      $display("FAIL tx_full_block: s_ready_seen=%b strobes=%0d, expected 0 4", saw_ready, mon_addr.size());
    end
    tx_full = 0;
    for (int i = 5; i <= 8; i++) begin
      push_word(i, 1'b0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tx_push_timeout: word %0d got no s_ready, expected a handshake", i);
      end
    end
    repeat (2) @(negedge pclk);
    checks++;
    if (tx_count !== 16'd8 || mon_addr.size() != 8) begin
      errors++;
      $display("FAIL tx_total: tx_count=%0d strobes=%0d, expected 8 8", tx_count, mon_addr.size());
    end
    for (int i = 0; i < 8 && i < mon_addr.size(); i++) begin
      checks++;
      if (mon_addr[i] !== 32'h04 || mon_wr[i] !== 1'b1 || mon_data[i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL tx_order[%0d]: addr=%h wr=%b data=%h, expected 00000004 1 %h",
                 i, mon_addr[i], mon_wr[i], mon_data[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_rx_path();
    do_reset();
    rx_empty = 0; m_ready = 0; prdata = 32'hDEAD_BEEF;
    @(negedge pclk);
    checks++;
    if (penable !== 1'b1 || pwrite !== 1'b0 || paddr !== 32'h28) begin
      errors++;
      $display("FAIL rx_read_strobe: pen=%b pwr=%b addr=%h, expected 1 0 00000028", penable, pwrite, paddr);
    end
    @(negedge pclk);
    checks++;
    if (penable !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_cap: pen=%b m_valid=%b, expected 0 0", penable, m_valid);
    end
    @(negedge pclk);
    prdata = 32'h0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rx_data: m_valid=%b m_data=%h, expected 1 deadbeef", m_valid, m_data);
    end
    repeat (10) @(negedge pclk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hDEAD_BEEF || mon_addr.size() != 1 || rx_count !== 16'd0) begin
      errors++;
      $display("FAIL rx_hold: m_valid=%b m_data=%h reads=%0d rx_count=%0d, expected 1 deadbeef 1 0",
               m_valid, m_data, mon_addr.size(), rx_count);
    end
    m_ready = 1;
    @(negedge pclk);
    rx_empty = 1;
    checks++;
    if (m_valid !== 1'b0 || rx_count !== 16'd1) begin
      errors++;
      $display("FAIL rx_handshake: m_valid=%b rx_count=%0d, expected 0 1", m_valid, rx_count);
    end
    m_ready = 0;
    repeat (3) @(negedge pclk);
    checks++;
    if (mon_addr.size() != 1) begin
      errors++;
      $display("FAIL rx_single_read: reads=%0d, expected 1", mon_addr.size());
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] exp_addr [7];
    logic        exp_wr   [7];
    int n;
    exp_addr = '{32'h04, 32'h28, 32'h00, 32'h04, 32'h28, 32'h04, 32'h28};
    exp_wr   = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
    do_reset();
    s_valid = 1; s_data = 32'hC0DE; rx_empty = 0; m_ready = 1; prdata = 32'h1111;
    n = 0;
    while (mon_addr.size() < 2 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    cfg_valid = 1; cfg_sel = 0; cfg_data = 32'hC5;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    cfg_valid = 0;
    n = 0;
    while (mon_addr.size() < 7 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    s_valid = 0; rx_empty = 1;
    repeat (4) @(negedge pclk);
    checks++;
    if (mon_addr.size() != 7 || tx_count !== 16'd3 || rx_count !== 16'd3) begin
      errors++;
      $display("FAIL arb_totals: strobes=%0d tx=%0d rx=%0d, expected 7 3 3", mon_addr.size(), tx_count, rx_count);
    end
    for (int i = 0; i < 7 && i < mon_addr.size(); i++) begin
      checks++;
      if (mon_addr[i] !== exp_addr[i] || mon_wr[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL arb_seq[%0d]: addr=%h wr=%b, expected %h %b", i, mon_addr[i], mon_wr[i], exp_addr[i], exp_wr[i]);
      end
    end
    checks++;
    if (mon_addr.size() > 2 && mon_data[2] !== 32'hC5) begin
      errors++;
      $display("FAIL arb_cfg_data: data=%h, expected 000000c5", mon_data[2]);
    end
  endtask

  task automatic test_reset_midtransfer();
    do_reset();
    s_valid = 1; s_data = 32'h99;
    @(negedge pclk);
    preset = 1;
    #1;
    checks++;
    if (penable !== 1'b0 || s_ready !== 1'b0 || tx_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: pen=%b srdy=%b tx=%0d, expected 0 0 0", penable, s_ready, tx_count);
    end
    s_valid = 0;
    @(negedge pclk);
    preset = 0;
    repeat (2) @(negedge pclk);
    checks++;
    if (tx_count !== 16'd0 || mon_addr.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_after: tx=%0d strobes=%0d, expected 0 0", tx_count, mon_addr.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    force dut.tx_count = 16'hFFFE;
    @(negedge pclk);
    release dut.tx_count;
    push_word(32'hAA, 1'b0, ok);
    checks++;
    if (!ok || tx_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_ffff: ok=%b tx_count=%h, expected 1 ffff", ok, tx_count);
    end
    push_word(32'hBB, 1'b0, ok);
    checks++;
    if (!ok || tx_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: ok=%b tx_count=%h, expected 1 0000", ok, tx_count);
    end
  endtask

  initial begin
    preset = 1;
    idle_inputs();
    test_reset();
    test_config();
    test_tx_flow();
    test_rx_path();
    test_arbitration();
    test_reset_midtransfer();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_apb_master.md
# i2s_apb_master

Bus initiator that drives the APB-style register port of one or two I2S transceiver instances from the system side. It accepts control words and a transmit sample stream, issues single-cycle register writes to the control and TxFIFO-data addresses, and polls the RxFIFO-data address to produce a receive sample stream. It replaces hand-sequenced bus traffic with a flow-controlled engine that never overruns the TxFIFO or reads an empty RxFIFO.

## Interface
- TX_BASE, 32'h00, base address of the transmitting transceiver
- RX_BASE, 32'h20, base address of the receiving transceiver
- CTRL_OFS, 32'h0, control-register offset
- TXD_OFS, 32'h4, TxFIFO data offset
- RXD_OFS, 32'h8, RxFIFO data offset

Ports:
- pclk  in  1  bus clock; all logic on its rising edge
- preset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  control-word request
- cfg_sel  in  1  0 = TX_BASE, 1 = RX_BASE
- cfg_data  in  32  control word (packed control-word layout)
- cfg_ready  out  1  control word accepted this cycle
- s_valid / s_ready  in / out  1 / 1  TX sample handshake
- s_data  in  32  TX sample
- m_valid / m_ready  out / in  1 / 1  RX sample handshake
- m_data  out  32  RX sample
- tx_full  in  1  TxFIFO full flag (sideband)
- rx_empty  in  1  RxFIFO empty flag (sideband)
- penable, pwrite  out  1  bus strobe, direction
- paddr, pwdata  out  32  bus address, write data
- prdata  in  32  bus read data, valid the cycle after a read strobe
- tx_count, rx_count  out  16  words written / words delivered, wrap at 16'hFFFF -> 0

## Operation
- FSM states: IDLE, CFG, WR, RD, CAP.
- IDLE: selects one request per cycle, fixed priority cfg > (tx/rx round-robin). Eligibility: tx needs s_valid & !tx_full; rx needs !rx_empty & !m_valid. Round-robin bit `last` flips to the granted side; when only one side is eligible, it is granted regardless of `last`.
- CFG: penable=1, pwrite=1, paddr = (cfg_sel ? RX_BASE : TX_BASE) + CTRL_OFS, pwdata = cfg_data; cfg_ready=1 this cycle only; -> IDLE.
- WR: penable=1, pwrite=1, paddr = TX_BASE + TXD_OFS, pwdata = s_data; s_ready=1 this cycle only; tx_count++; -> IDLE.
- RD: penable=1, pwrite=0, paddr = RX_BASE + RXD_OFS; -> CAP.
- CAP: penable=0; m_data <= prdata, m_valid <= 1; -> IDLE.
- m_valid clears on m_valid & m_ready; rx_count++ on that handshake.
- Request inputs are sampled in IDLE and held by the requester until ready (valid must not drop without ready).
- In every state other than CFG/WR/RD: penable=0, pwrite=0; paddr/pwdata hold last value.

## Timing
- Reset (async assert, sync release): state=IDLE, penable=0, pwrite=0, paddr=0, pwdata=0, cfg_ready=0, s_ready=0, m_valid=0, m_data=0, tx_count=0, rx_count=0, last=0 (tx wins first tie).
- Write: request seen in IDLE at cycle N -> strobe in cycle N+1 -> back to IDLE at N+2; max 1 write per 2 cycles.
- Read: IDLE N -> RD N+1 -> CAP N+2 (prdata sampled) -> m_valid high from N+3.
- tx_full rising while in WR: current write completes (flag was clear at grant); no further WR until clear.
- Simultaneous cfg and data requests: cfg granted; data waits, round-robin bit unchanged.
- m_valid held with m_ready=0: no RD issued (single-entry output buffer, no drop).
- Reset asserted mid-transfer: penable drops asynchronously; partial handshake lost, no ready pulse.
- Counter wrap: 16'hFFFF + 1 = 16'h0000, no flag.

## Test plan
- Reset: hold preset=1 with s_valid=1, rx_empty=0 -> all outputs zero, no strobe; release -> first strobe is WR to 32'h04.
- Config: cfg_valid with cfg_sel=1, cfg_data=32'hA5A5_0001 -> one cycle penable=1, pwrite=1, paddr=32'h20, pwdata=32'hA5A5_0001, cfg_ready pulse.
- Tx flow control: stream 8 words 32'h1..32'h8, tx_full=1 after 4th -> exactly 4 writes to 32'h04, resume on clear, tx_count=8, order preserved.
- Rx path: rx_empty=0, prdata=32'hDEAD_BEEF on CAP, m_ready=0 for 10 cycles -> single read at 32'h28, m_data held, no second read until m_ready.
- Arbitration: s_valid=1, rx_empty=0 continuously, m_ready=1 -> strobes alternate 32'h04 / 32'h28; cfg_valid injected -> CFG strobe next, alternation resumes.
- Wrap: preload 65535 tx handshakes -> tx_count=16'hFFFF, one more -> 16'h0000.
